// File: rtl/dmem_port_arbiter.sv
// Single-port data memory sequencer shared by the MA stage and an auxiliary port.
// One access in flight at a time, fixed memory latency, MA priority with aux anti-starvation.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ma_req_i,
    input  logic              ma_we_i,
    input  logic [ADDR_W-1:0] ma_addr_i,
    input  logic [DATA_W-1:0] ma_wdata_i,
    output logic [DATA_W-1:0] ma_rdata_o,
    output logic              ma_done_o,
    output logic              ma_stall_o,

    input  logic              aux_req_i,
    input  logic              aux_we_i,
    input  logic [ADDR_W-1:0] aux_addr_i,
    input  logic [DATA_W-1:0] aux_wdata_i,
    output logic              aux_gnt_o,
    output logic [DATA_W-1:0] aux_rdata_o,
    output logic              aux_done_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned LatW = $clog2(MEM_LAT + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              owner_aux_q, owner_aux_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic [StW-1:0]    starve_q, starve_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

    logic any_req;
    logic aux_wins;

    assign any_req  = ma_req_i | aux_req_i;
    assign aux_wins = aux_req_i & (~ma_req_i | (starve_q == StW'(STARVE_MAX)));

    always_comb begin
        state_d     = state_q;
        owner_aux_d = owner_aux_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ma_rdata_d  = ma_rdata_q;
        aux_rdata_d = aux_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (aux_wins || !aux_req_i) begin
                    starve_d = '0;
                end else if (starve_q != StW'(STARVE_MAX)) begin
                    starve_d = starve_q + StW'(1);
                end
                if (any_req) begin
                    state_d     = StIssue;
                    owner_aux_d = aux_wins;
                    mem_we_d    = aux_wins ? aux_we_i    : ma_we_i;
                    mem_addr_d  = aux_wins ? aux_addr_i  : ma_addr_i;
                    mem_wdata_d = aux_wins ? aux_wdata_i : ma_wdata_i;
                end
            end
            StIssue: begin
                state_d = StWait;
                lat_d   = LatW'(MEM_LAT);
            end
            StWait: begin
                lat_d = lat_q - LatW'(1);
                if (lat_q == LatW'(1)) begin
                    state_d = StDone;
                    // Stores leave the owner's read data untouched.
                    if (!mem_we_q) begin
                        if (owner_aux_q) begin
                            aux_rdata_d = mem_rdata_i;
                        end else begin
                            ma_rdata_d = mem_rdata_i;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_aux_q <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ma_rdata_q  <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_aux_q <= owner_aux_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ma_rdata_q  <= ma_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    assign mem_en_o    = (state_q == StIssue);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    assign ma_done_o   = (state_q == StDone) & ~owner_aux_q;
    assign aux_done_o  = (state_q == StDone) & owner_aux_q;
    assign aux_gnt_o   = owner_aux_q & (state_q != StIdle);
    // Stall covers time spent queued behind an aux access as well.
    assign ma_stall_o  = ma_req_i & ~ma_done_o;

    assign ma_rdata_o  = ma_rdata_q;
    assign aux_rdata_o = aux_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed timeline scenarios plus randomized two-requester traffic
// checked against a transaction-level model of arbitration, timing and memory contents.
module tb_dmem_port_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          D          = 2 + MEM_LAT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ma_req = 1'b0, ma_we = 1'b0;
    logic [31:0] ma_addr = '0, ma_wdata = '0;
    logic [31:0] ma_rdata;
    logic        ma_done, ma_stall;
    logic        aux_req = 1'b0, aux_we = 1'b0;
    logic [31:0] aux_addr = '0, aux_wdata = '0;
    logic        aux_gnt, aux_done;
    logic [31:0] aux_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_ma_rdata  = '0;
    logic [31:0] exp_aux_rdata = '0;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ma_req_i(ma_req), .ma_we_i(ma_we), .ma_addr_i(ma_addr), .ma_wdata_i(ma_wdata),
        .ma_rdata_o(ma_rdata), .ma_done_o(ma_done), .ma_stall_o(ma_stall),
        .aux_req_i(aux_req), .aux_we_i(aux_we), .aux_addr_i(aux_addr),
        .aux_wdata_i(aux_wdata), .aux_gnt_o(aux_gnt), .aux_rdata_o(aux_rdata),
        .aux_done_o(aux_done),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: samples at end of the issue cycle, read data valid only in the last wait cycle.
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [256];
    logic [31:0] rd_data = '0;
    int          rd_cnt = 0;

    always @(posedge clk) begin
        if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
        if (pl_en) mem[pl_idx] <= pl_data;
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else begin
                rd_data <= mem[mem_addr[9:2]];
                rd_cnt  <= MEM_LAT;
            end
        end
    end
    assign mem_rdata = (rd_cnt == 1) ? rd_data : 32'hDEAD_BEEF;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_idx = idx; pl_data = data; pl_en = 1'b1;
        next_cycle();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) next_cycle();
        #1;
        n_cmp++;
        if ({mem_en, mem_we, ma_done, aux_done, aux_gnt, ma_stall} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {mem_en, mem_we, ma_done, aux_done, aux_gnt, ma_stall});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 64'b0) begin
            n_err++; $display("FAIL reset_mem_bus got %h exp 0", {mem_addr, mem_wdata});
        end
        n_cmp++;
        if ({ma_rdata, aux_rdata} !== 64'b0) begin
            n_err++; $display("FAIL reset_rdata got %h exp 0", {ma_rdata, aux_rdata});
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_ma_load();
        preload(8'd4, 32'hA5A5_A5A5);
        ma_we = 1'b0; ma_addr = 32'h10; ma_wdata = '0; ma_req = 1'b1;
        for (int c = 0; c <= D; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_cmp++;
            if (mem_en !== (c == 1)) begin
                n_err++; $display("FAIL ld_mem_en c=%0d got %b exp %b", c, mem_en, c == 1);
            end
            if (c == 1) begin
                n_cmp++;
                if ({mem_addr, mem_we} !== {32'h10, 1'b0}) begin
                    n_err++; $display("FAIL ld_issue addr/we got %h/%b exp 10/0", mem_addr, mem_we);
                end
            end
            n_cmp++;
            if ({ma_done, ma_stall, aux_gnt} !== {c == D, c != D, 1'b0}) begin
                n_err++;
                $display("FAIL ld_done_stall c=%0d got %b%b%b exp %b%b0", c, ma_done, ma_stall,
                         aux_gnt, c == D, c != D);
            end
            if (c == D) begin
                n_cmp++;
                if (ma_rdata !== 32'hA5A5_A5A5) begin
                    n_err++; $display("FAIL ld_rdata got %h exp a5a5a5a5", ma_rdata);
                end
                exp_ma_rdata = 32'hA5A5_A5A5;
                ma_req = 1'b0;
            end
        end
        next_cycle();
    endtask

    task automatic test_store_load();
        preload(8'd4, 32'h0);
        for (int op = 0; op < 2; op++) begin
            ma_we = (op == 0); ma_addr = 32'h10; ma_wdata = 32'hA5A5_A5A5; ma_req = 1'b1;
            for (int c = 0; c <= D; c++) begin
                if (c > 0) next_cycle();
                #1;
                n_cmp++;
                if (mem_en !== (c == 1)) begin
                    n_err++; $display("FAIL st_mem_en op=%0d c=%0d got %b", op, c, mem_en);
                end
                if (c == 1 && op == 0) begin
                    n_cmp++;
                    if ({mem_we, mem_wdata} !== {1'b1, 32'hA5A5_A5A5}) begin
                        n_err++;
                        $display("FAIL st_issue we/wdata got %b/%h exp 1/a5a5a5a5", mem_we, mem_wdata);
                    end
                end
                n_cmp++;
                if (ma_done !== (c == D)) begin
                    n_err++; $display("FAIL st_done op=%0d c=%0d got %b", op, c, ma_done);
                end
                if (c == D) begin
                    if (op == 1) exp_ma_rdata = 32'hA5A5_A5A5;
                    n_cmp++;
                    if (ma_rdata !== exp_ma_rdata) begin
                        n_err++;
                        $display("FAIL st_rdata op=%0d got %h exp %h", op, ma_rdata, exp_ma_rdata);
                    end
                    ma_req = 1'b0;
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        preload(8'd8, 32'h5A5A_0001);
        ma_we = 1'b0; ma_addr = 32'h10; ma_req = 1'b1;
        aux_we = 1'b0; aux_addr = 32'h20; aux_req = 1'b1;
        for (int c = 0; c <= 2 * D + 1; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_cmp++;
            if ({mem_en, aux_gnt, ma_done, aux_done, ma_stall} !==
                {c == 1 || c == D + 2, c >= D + 2, c == D, c == 2 * D + 1, c < D}) begin
                n_err++;
                $display("FAIL cont_ctrl c=%0d got en,gnt,mdone,adone,stall=%b%b%b%b%b", c,
                         mem_en, aux_gnt, ma_done, aux_done, ma_stall);
            end
            if (c == 1 || c == D + 2) begin
                n_cmp++;
                if (mem_addr !== ((c == 1) ? 32'h10 : 32'h20)) begin
                    n_err++; $display("FAIL cont_addr c=%0d got %h", c, mem_addr);
                end
            end
            if (c == D) ma_req = 1'b0;
            if (c == 2 * D + 1) begin
                exp_aux_rdata = 32'h5A5A_0001;
                n_cmp++;
                if (aux_rdata !== exp_aux_rdata) begin
                    n_err++; $display("FAIL cont_aux_rdata got %h exp %h", aux_rdata, exp_aux_rdata);
                end
                aux_req = 1'b0;
            end
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit exp_w [10];
        int st = 0;
        int k = 0;
        for (int i = 0; i < 10; i++) begin
            exp_w[i] = (st == STARVE_MAX);
            st = exp_w[i] ? 0 : ((st < STARVE_MAX) ? st + 1 : st);
        end
        ma_we = 1'b0; ma_addr = 32'h10; ma_req = 1'b1;
        aux_we = 1'b0; aux_addr = 32'h20; aux_req = 1'b1;
        for (int c = 0; c < 12 * (D + 1) && k < 10; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_cmp++;
            if (c == k * (D + 1) + D) begin
                if ({ma_done, aux_done} !== {!exp_w[k], exp_w[k]}) begin
                    n_err++;
                    $display("FAIL starve_winner k=%0d got ma,aux=%b%b exp aux=%b", k, ma_done,
                             aux_done, exp_w[k]);
                end
                k++;
                if (k == 10) begin ma_req = 1'b0; aux_req = 1'b0; end
            end else if ({ma_done, aux_done} !== 2'b00) begin
                n_err++; $display("FAIL starve_spurious_done c=%0d got %b%b", c, ma_done, aux_done);
            end
        end
        n_cmp++;
        if (k != 10) begin
            n_err++; $display("FAIL starve_timeout done_count got %0d exp 10", k);
        end
        ma_req = 1'b0; aux_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        ma_we = 1'b0; ma_addr = 32'h10; ma_req = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            if (c > 0) next_cycle();
        end
        #1;
        rst = 1'b1; ma_req = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, ma_done, aux_done, aux_gnt, ma_stall, mem_addr, mem_wdata,
             ma_rdata, aux_rdata} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs en=%b addr=%h ma_rdata=%h aux_rdata=%h exp all 0",
                     mem_en, mem_addr, ma_rdata, aux_rdata);
        end
        exp_ma_rdata = '0; exp_aux_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            n_cmp++;
            if (ma_done !== 1'b0) begin
                n_err++; $display("FAIL rstmid_no_done i=%0d got %b exp 0", i, ma_done);
            end
        end
        rst = 1'b0;
        next_cycle();
        ma_req = 1'b1;
        for (int c = 0; c <= D; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_cmp++;
            if ({mem_en, ma_done} !== {c == 1, c == D}) begin
                n_err++;
                $display("FAIL rstmid_relaunch c=%0d got en,done=%b%b", c, mem_en, ma_done);
            end
            if (c == D) begin
                exp_ma_rdata = 32'hA5A5_A5A5;
                n_cmp++;
                if (ma_rdata !== exp_ma_rdata) begin
                    n_err++; $display("FAIL rstmid_rdata got %h exp %h", ma_rdata, exp_ma_rdata);
                end
                ma_req = 1'b0;
            end
        end
        next_cycle();
    endtask

    task automatic test_aux_rw();
        for (int op = 0; op < 2; op++) begin
            aux_we = (op == 0); aux_addr = 32'h20; aux_wdata = 32'h1234_5678; aux_req = 1'b1;
            for (int c = 0; c <= D; c++) begin
                if (c > 0) next_cycle();
                #1;
                n_cmp++;
                if ({mem_en, aux_gnt, aux_done, ma_stall, ma_done} !==
                    {c == 1, c >= 1, c == D, 2'b00}) begin
                    n_err++;
                    $display("FAIL aux_ctrl op=%0d c=%0d got en,gnt,done,stall,mdone=%b%b%b%b%b",
                             op, c, mem_en, aux_gnt, aux_done, ma_stall, ma_done);
                end
                if (c == 1 && op == 0) begin
                    n_cmp++;
                    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h20, 32'h1234_5678}) begin
                        n_err++;
                        $display("FAIL aux_issue got we=%b addr=%h wdata=%h", mem_we, mem_addr,
                                 mem_wdata);
                    end
                end
                if (c == D) begin
                    if (op == 1) exp_aux_rdata = 32'h1234_5678;
                    n_cmp++;
                    if (aux_rdata !== exp_aux_rdata) begin
                        n_err++;
                        $display("FAIL aux_rdata op=%0d got %h exp %h", op, aux_rdata, exp_aux_rdata);
                    end
                    aux_req = 1'b0;
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [8];
        int ref_st = 0;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            preload(8'(64 + i), ref_mem[i]);
        end
        for (int it = 0; it < 40; it++) begin
            int pat = $urandom_range(0, 2);
            bit use_ma = (pat != 1);
            bit use_aux = (pat != 0);
            bit s_aux [2];
            bit s_we [2];
            int s_idx [2];
            logic [31:0] s_dat [2];
            int n_slot = (use_ma && use_aux) ? 2 : 1;
            bit aux_first = use_aux && (!use_ma || ref_st == STARVE_MAX);
            int last;
            ref_st = (use_aux && !aux_first) ? ((ref_st < STARVE_MAX) ? ref_st + 1 : ref_st) : 0;
            for (int s = 0; s < 2; s++) begin
                s_aux[s] = (s == 0) ? aux_first : !aux_first;
                s_we[s]  = 1'($urandom_range(0, 1));
                s_idx[s] = $urandom_range(0, 7);
                s_dat[s] = $urandom;
                if (s_aux[s]) begin
                    aux_we = s_we[s]; aux_addr = 32'h100 + 32'(s_idx[s]) * 4;
                    aux_wdata = s_dat[s]; aux_req = use_aux;
                end else begin
                    ma_we = s_we[s]; ma_addr = 32'h100 + 32'(s_idx[s]) * 4;
                    ma_wdata = s_dat[s]; ma_req = use_ma;
                end
            end
            last = (n_slot == 2) ? 2 * D + 1 : D;
            for (int c = 0; c <= last; c++) begin
                bit e_en = 0, e_md = 0, e_ad = 0, e_gnt = 0;
                if (c > 0) next_cycle();
                #1;
                for (int s = 0; s < n_slot; s++) begin
                    int iss = (s == 0) ? 1 : D + 2;
                    int dn = iss + MEM_LAT + 1;
                    if (c == iss) begin
                        e_en = 1;
                        n_cmp++;
                        if ({mem_we, mem_addr} !== {s_we[s], 32'h100 + 32'(s_idx[s]) * 4} ||
                            (s_we[s] && mem_wdata !== s_dat[s])) begin
                            n_err++;
                            $display("FAIL rnd_issue it=%0d s=%0d got we=%b addr=%h wd=%h", it, s,
                                     mem_we, mem_addr, mem_wdata);
                        end
                        if (s_we[s]) ref_mem[s_idx[s]] = s_dat[s];
                    end
                    if (s_aux[s] && c >= iss && c <= dn) e_gnt = 1;
                    if (c == dn) begin
                        if (s_aux[s]) e_ad = 1; else e_md = 1;
                    end
                end
                n_cmp++;
                if ({mem_en, ma_done, aux_done, aux_gnt, ma_stall} !==
                    {e_en, e_md, e_ad, e_gnt, ma_req & ~e_md}) begin
                    n_err++;
                    $display("FAIL rnd_ctrl it=%0d c=%0d got en,md,ad,gnt,stall=%b%b%b%b%b exp %b%b%b%b%b",
                             it, c, mem_en, ma_done, aux_done, aux_gnt, ma_stall, e_en, e_md,
                             e_ad, e_gnt, ma_req & ~e_md);
                end
                for (int s = 0; s < n_slot; s++) begin
                    if (c == ((s == 0) ? D : 2 * D + 1)) begin
                        if (s_aux[s]) begin
                            if (!s_we[s]) exp_aux_rdata = ref_mem[s_idx[s]];
                            n_cmp++;
                            if (aux_rdata !== exp_aux_rdata) begin
                                n_err++;
                                $display("FAIL rnd_aux_rdata it=%0d got %h exp %h", it, aux_rdata,
                                         exp_aux_rdata);
                            end
                            aux_req = 1'b0;
                        end else begin
                            if (!s_we[s]) exp_ma_rdata = ref_mem[s_idx[s]];
                            n_cmp++;
                            if (ma_rdata !== exp_ma_rdata) begin
                                n_err++;
                                $display("FAIL rnd_ma_rdata it=%0d got %h exp %h", it, ma_rdata,
                                         exp_ma_rdata);
                            end
                            ma_req = 1'b0;
                        end
                    end
                end
            end
            if (n_slot == 2) ref_st = 0;
            ma_req = 1'b0; aux_req = 1'b0;
            next_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ma_load();
        test_store_load();
        test_contention();
        test_starvation();
        test_reset_mid();
        test_aux_rw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
